// File: rtl/usb_crc_engine.sv
// Serial USB CRC generator/checker: accumulates payload bits, can serialise the
// inverted remainder onto the line, and flags the residual for RX checking.
module usb_crc_engine #(
  parameter int               CRC_W    = 16,
  parameter logic [CRC_W-1:0] POLY     = 16'h8005,
  parameter logic [CRC_W-1:0] INIT     = {CRC_W{1'b1}},
  parameter logic [CRC_W-1:0] RESIDUAL = 16'h800D
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  input  logic             bit_strobe,
  input  logic             data_bit,
  input  logic             append_req,
  output logic             crc_bit,
  output logic             append_busy,
  output logic             append_done,
  output logic [CRC_W-1:0] crc_out,
  output logic             residual_ok
);

  localparam int CNT_W = (CRC_W > 2) ? $clog2(CRC_W) : 1;

  typedef enum logic [1:0] {IDLE, ACCUM, APPEND} state_t;

  state_t             state_q, state_d;
  logic [CRC_W-1:0]   q_q, q_d;
  logic [CRC_W-1:0]   snap_q, snap_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               done_q, done_d;
  logic               data_strobe;
  logic               last_strobe;

  function automatic logic [CRC_W-1:0] crc_step(input logic [CRC_W-1:0] cur,
                                                input logic b);
    logic fb;
    fb = b ^ cur[CRC_W-1];
    return {cur[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
  endfunction

  assign data_strobe = bit_strobe & enable & (state_q != APPEND);
  assign last_strobe = (state_q == APPEND) & bit_strobe & (cnt_q == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      q_q     <= INIT;
      snap_q  <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      snap_q  <= snap_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (append_req)       state_d = APPEND;
          else if (data_strobe) state_d = ACCUM;
        end
        ACCUM: begin
          if (append_req) state_d = APPEND;
        end
        APPEND: begin
          if (last_strobe) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // The snapshot is taken from q_d so a data bit strobed alongside append_req is covered.
  always_comb begin
    q_d    = q_q;
    snap_d = snap_q;
    cnt_d  = cnt_q;
    done_d = 1'b0;
    if (clear) begin
      q_d    = INIT;
      snap_d = '0;
      cnt_d  = '0;
    end else if (state_q == APPEND) begin
      if (bit_strobe) begin
        q_d    = crc_step(q_q, snap_q[CRC_W-1]);
        snap_d = {snap_q[CRC_W-2:0], 1'b0};
        if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
        done_d = last_strobe;
      end
    end else begin
      if (data_strobe) q_d = crc_step(q_q, data_bit);
      if (append_req) begin
        snap_d = ~q_d;
        cnt_d  = CNT_W'(CRC_W - 1);
      end
    end
  end

  always_comb begin
    append_busy = (state_q == APPEND);
    crc_bit     = append_busy & snap_q[CRC_W-1];
    append_done = done_q;
    crc_out     = ~q_q;
    residual_ok = (q_q == RESIDUAL);
  end

endmodule
